pie_encoder: RTL and testbench
==============================

Name: pie_encoder

Overview:
- Downstream neighbour of the reader control FSM. Consumes its serial command bitstream (data, sending, preamble flag) and produces the Gen2 PIE (pulse-interval encoding) baseband envelope that keys the TX modulator.
- Generates the delimiter, data-0, RTcal and (for Query only) TRcal before the data bits, then one PIE symbol per bit.
- Holds continuous wave (CW) whenever no command is active.

Parameters:
- TARI_CYC, 25, data-0 symbol length in clk cycles
- PW_CYC, 12, low-pulse width ending every symbol
- DELIM_CYC, 25, delimiter low length
- RTCAL_CYC, 75, RTcal length (data-0 + data-1)
- TRCAL_CYC, 150, TRcal length
- CW_MIN_CYC, 500, minimum CW before a new frame (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_dat  in  1  current command bit from the control FSM
- sending  in  1  control FSM is in a send state
- preamble  in  1  high means full preamble (with TRcal); low means frame-sync
- in_rdy  out  1  one-cycle pulse: current bit consumed; the FSM advances its bit on this pulse
- tx_env  out  1  envelope: 1 = CW/high, 0 = attenuated
- busy  out  1  high in every state except CW

Behaviour:
- Reset values: tx_env=1, in_rdy=0, busy=0, state=CW, counters=0. All outputs are registered.
- States: CW, DELIM, SYNC_D0, RTCAL, TRCAL, DATA.
- Shared down-counter (width = $clog2(TRCAL_CYC+1)) times every segment.
- CW: tx_env=1. If sending=1:
  - latch preamble into pre_q;
  - load DELIM_CYC;
  - go to DELIM.
- DELIM: tx_env=0 for DELIM_CYC cycles, then go to SYNC_D0.
- Symbol shape: every symbol of length L is high for L-PW_CYC cycles, then low for PW_CYC cycles.
- SYNC_D0 (L=TARI_CYC) -> RTCAL (L=RTCAL_CYC) -> TRCAL if pre_q, else DATA. TRCAL (L=TRCAL_CYC) -> DATA.
- DATA, first cycle of each symbol:
  - sample in_dat;
  - L = TARI_CYC for 0, L = 2*TARI_CYC for 1.
- DATA, last cycle of each symbol: in_rdy=1 only if sending=1.
  - Cycle after the pulse: if sending=1, start the next symbol with the new in_dat (no gap cycle).
  - Otherwise return to CW.
- sending falls mid-symbol or mid-preamble: finish the current symbol's low pulse, suppress in_rdy, return to CW.
- sending is ignored in DELIM and preamble states, except as the exit check at segment end.
- in_rdy never asserts outside DATA. There is never more than one pulse per symbol.
- tx_env never glitches within a segment.
- Reset mid-frame: CW with tx_env=1 on the next edge. No in_rdy.
- preamble changing after the frame starts has no effect.

Optional Feature:
- Macro PIE_CW_GUARD_EN.
- Defined:
  - a CW_MIN_CYC counter restarts on every entry to CW;
  - a rising of sending is held off (busy stays 0, tx_env=1) until CW_MIN_CYC cycles of CW have elapsed;
  - the counter saturates after reset, so the first frame after reset also waits CW_MIN_CYC.
- Undefined: a frame starts on the cycle after sending is seen in CW.

Decomposition:
- Shared package pie_pkg:
  - state enum;
  - default timing constants (TARI, PW, DELIM, RTCAL, TRCAL in cycles);
  - counter width function.
- One natural sub-module, pie_symbol_timer:
  - inputs: load, length, pw;
  - outputs: level, last;
  - reused for every segment.
- The top level holds the FSM and handshake.

Test Plan:
- Reset, then idle 100 cycles with sending=0 -> tx_env=1, busy=0, in_rdy never 1.
- Query frame, preamble=1, bits 1,0 (sending drops after the 2nd in_rdy):
  - tx_env sequence: low 25; high 13/low 12; high 63/low 12; high 138/low 12; high 38/low 12; high 13/low 12; then CW;
  - in_rdy pulses exactly 2 times, each on the last low cycle of a data symbol.
- Frame-sync, preamble=0, bit 0 -> no 150-cycle TRcal segment; the data symbol directly follows RTcal.
- sending deasserts 5 cycles into a data-1 symbol -> symbol completes (50 cycles), no in_rdy, CW after.
- rst asserted in the middle of RTCAL -> next cycle tx_env=1, busy=0; a new sending starts a clean delimiter.
- With PIE_CW_GUARD_EN, sending raised 100 cycles after the previous frame ends -> delimiter starts exactly 500 cycles after CW entry.

Source files
------------

// File: rtl/pie_pkg.sv
// pie_pkg: shared state enum, default PIE timing and counter sizing.
// Used by pie_encoder and pie_symbol_timer.
package pie_pkg;

  typedef enum logic [2:0] {
    S_CW,
    S_DELIM,
    S_SYNC_D0,
    S_RTCAL,
    S_TRCAL,
    S_DATA
  } state_t;

  localparam int TARI_CYC   = 25;
  localparam int PW_CYC     = 12;
  localparam int DELIM_CYC  = 25;
  localparam int RTCAL_CYC  = 75;
  localparam int TRCAL_CYC  = 150;
  localparam int CW_MIN_CYC = 500;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pie_symbol_timer.sv
// pie_symbol_timer: down-counter shaping one segment (high, then pw low).
// When idle (count 0) the level rests high, which is the CW envelope.
import pie_pkg::*;

module pie_symbol_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] length,
  input  logic [W-1:0] pw,
  output logic         level,
  output logic         last,
  output logic         pre_last
);

  logic [W-1:0] cnt;
  logic [W-1:0] pw_q;
  logic [W-1:0] cnt_n;
  logic [W-1:0] pw_n;

  // next count: reload on load, else count down to zero
  always_comb begin
    cnt_n = cnt;
    pw_n  = pw_q;
    if (load) begin
      cnt_n = length;
      pw_n  = pw;
    end else if (cnt != '0) begin
      cnt_n = cnt - W'(1);
    end
  end

  // level/last are registered views of the cycle being presented
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      pw_q     <= '0;
      level    <= 1'b1;
      last     <= 1'b0;
      pre_last <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      pw_q     <= pw_n;
      level    <= (cnt_n == '0) || (cnt_n > pw_n);
      last     <= (cnt_n == W'(1));
      pre_last <= (cnt_n == W'(2));
    end
  end

endmodule

// File: rtl/pie_encoder.sv
// pie_encoder: Gen2 PIE envelope generator fed by the reader control FSM.
// Optional CW hold-off before a new frame: define PIE_CW_GUARD_EN.
import pie_pkg::*;

module pie_encoder (
  input  logic clk,
  input  logic rst,
  input  logic in_dat,
  input  logic sending,
  input  logic preamble,
  output logic in_rdy,
  output logic tx_env,
  output logic busy
);

  localparam int W = cnt_w(TRCAL_CYC);

  localparam logic [W-1:0] L_TARI  = W'(TARI_CYC);
  localparam logic [W-1:0] L_TARI2 = W'(2 * TARI_CYC);
  localparam logic [W-1:0] L_D0_R  = W'(TARI_CYC - 1);
  localparam logic [W-1:0] L_D1_R  = W'(2 * TARI_CYC - 1);
  localparam logic [W-1:0] L_PW    = W'(PW_CYC);
  localparam logic [W-1:0] L_DELIM = W'(DELIM_CYC);
  localparam logic [W-1:0] L_RTCAL = W'(RTCAL_CYC);
  localparam logic [W-1:0] L_TRCAL = W'(TRCAL_CYC);

  state_t       state, state_n;
  logic         pre_q, pre_n;
  logic         first_q, first_n;
  logic         abort_q, abort_n;
  logic         rdy_n;
  logic         load;
  logic [W-1:0] len;
  logic [W-1:0] pwv;
  logic         level;
  logic         last;
  logic         pre_last;
  logic         cw_ok;

`ifdef PIE_CW_GUARD_EN
  localparam int GW = cnt_w(CW_MIN_CYC);
  logic [GW-1:0] cw_cnt;

  assign cw_ok = (cw_cnt >= GW'(CW_MIN_CYC - 1));

  // cycles spent in CW, restarted on every frame, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      cw_cnt <= '0;
    end else if (state != S_CW) begin
      cw_cnt <= '0;
    end else if (!cw_ok) begin
      cw_cnt <= cw_cnt + GW'(1);
    end
  end
`else
  assign cw_ok = 1'b1;
`endif

  pie_symbol_timer #(.W(W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .length   (len),
    .pw       (pwv),
    .level    (level),
    .last     (last),
    .pre_last (pre_last)
  );

  assign tx_env = level;

  // next state, segment loads and handshake
  always_comb begin
    state_n = state;
    pre_n   = pre_q;
    first_n = 1'b0;
    abort_n = abort_q;
    rdy_n   = 1'b0;
    load    = 1'b0;
    len     = L_TARI;
    pwv     = L_PW;
    unique case (state)
      S_CW: begin
        if (sending && cw_ok) begin
          pre_n   = preamble;
          abort_n = 1'b0;
          load    = 1'b1;
          len     = L_DELIM;
          pwv     = L_DELIM;
          state_n = S_DELIM;
        end
      end
      S_DELIM: begin
        if (last) begin
          if (sending) begin
            load    = 1'b1;
            len     = L_TARI;
            state_n = S_SYNC_D0;
          end else begin
            state_n = S_CW;
          end
        end
      end
      S_SYNC_D0: begin
        if (last) begin
          if (sending) begin
            load    = 1'b1;
            len     = L_RTCAL;
            state_n = S_RTCAL;
          end else begin
            state_n = S_CW;
          end
        end
      end
      S_RTCAL: begin
        if (last) begin
          if (!sending) begin
            state_n = S_CW;
          end else if (pre_q) begin
            load    = 1'b1;
            len     = L_TRCAL;
            state_n = S_TRCAL;
          end else begin
            load    = 1'b1;
            len     = L_TARI2;
            first_n = 1'b1;
            state_n = S_DATA;
          end
        end
      end
      S_TRCAL: begin
        if (last) begin
          if (sending) begin
            load    = 1'b1;
            len     = L_TARI2;
            first_n = 1'b1;
            state_n = S_DATA;
          end else begin
            state_n = S_CW;
          end
        end
      end
      S_DATA: begin
        abort_n = abort_q | ~sending;
        rdy_n   = pre_last && !first_q
                  && sending && !abort_q;
        if (first_q) begin
          load = 1'b1;
          len  = in_dat ? L_D1_R : L_D0_R;
        end else if (last) begin
          if (sending && !abort_q) begin
            load    = 1'b1;
            len     = L_TARI2;
            first_n = 1'b1;
            abort_n = 1'b0;
          end else begin
            state_n = S_CW;
          end
        end
      end
      default: state_n = S_CW;
    endcase
  end

  // FSM state and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CW;
      pre_q   <= 1'b0;
      first_q <= 1'b0;
      abort_q <= 1'b0;
      in_rdy  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      pre_q   <= pre_n;
      first_q <= first_n;
      abort_q <= abort_n;
      in_rdy  <= rdy_n;
      busy    <= (state_n != S_CW);
    end
  end

endmodule

// File: tb/tb_pie_encoder.sv
// tb_pie_encoder: directed vector table for the PIE envelope encoder.
// Measures envelope run lengths and in_rdy placement per frame.
module tb_pie_encoder;

  logic clk = 1'b0;
  logic rst;
  logic in_dat;
  logic sending;
  logic preamble;
  logic in_rdy;
  logic tx_env;
  logic busy;

  int total = 0;
  int bad   = 0;

  pie_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .in_dat   (in_dat),
    .sending  (sending),
    .preamble (preamble),
    .in_rdy   (in_rdy),
    .tx_env   (tx_env),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pre;
    logic       flip;
    int         nbits;
    logic [3:0] bits;
    int         abort_at;
    int         nruns;
    int         runs[16];
    int         rdy;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run_frame(input int k, input vec_t v);
    int   got[16];
    int   lead, gn, cur_len, rdy, rdy_bad, bi, cyc;
    logic cur_lvl, started, done, e, r, b;
    lead = 0; gn = 0; cur_len = 0; rdy = 0;
    rdy_bad = 0; bi = 0; cyc = 0;
    cur_lvl = 1'b1; started = 1'b0; done = 1'b0;
    for (int i = 0; i < 16; i++) got[i] = 0;
    in_dat   = v.bits[0];
    preamble = v.pre;
    sending  = 1'b1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      e = tx_env; r = in_rdy; b = busy;
      if (!started) begin
        if (!e) begin
          started = 1'b1; cur_lvl = 1'b0; cur_len = 1;
        end else begin
          lead++;
        end
      end else if (!b) begin
        if (gn < 16) got[gn] = cur_len;
        gn++;
        done = 1'b1;
        chk($sformatf("v%0d_cw_env", k), int'(e), 1);
      end else if (e == cur_lvl) begin
        cur_len++;
      end else begin
        if (gn < 16) got[gn] = cur_len;
        gn++;
        cur_lvl = e; cur_len = 1;
      end
      if (r) begin
        rdy++;
        if (e || cur_len != 12) rdy_bad++;
        bi++;
        if (bi >= v.nbits) sending = 1'b0;
        else in_dat = v.bits[bi];
      end
      if (started && v.flip) preamble = ~v.pre;
      if (v.abort_at > 0 && gn == 5 && cur_lvl
          && cur_len == v.abort_at) sending = 1'b0;
    end
    sending = 1'b0;
    if (!done) chk($sformatf("v%0d_timeout", k), 0, 1);
`ifndef PIE_CW_GUARD_EN
    chk($sformatf("v%0d_lead", k), lead, 0);
`endif
    chk($sformatf("v%0d_nruns", k), gn, v.nruns);
    for (int i = 0; i < v.nruns; i++)
      chk($sformatf("v%0d_run%0d", k, i), got[i], v.runs[i]);
    chk($sformatf("v%0d_rdy_cnt", k), rdy, v.rdy);
    chk($sformatf("v%0d_rdy_pos", k), rdy_bad, 0);
  endtask

  initial begin
    int env_bad, busy_bad, rdy_seen, fall;

    vt[0].pre = 1'b1; vt[0].flip = 1'b0;
    vt[0].nbits = 2; vt[0].bits = 4'b0001;
    vt[0].abort_at = 0; vt[0].nruns = 11; vt[0].rdy = 2;
    vt[0].runs = '{25, 13, 12, 63, 12, 138, 12, 38,
                   12, 13, 12, 0, 0, 0, 0, 0};

    vt[1].pre = 1'b0; vt[1].flip = 1'b0;
    vt[1].nbits = 1; vt[1].bits = 4'b0000;
    vt[1].abort_at = 0; vt[1].nruns = 7; vt[1].rdy = 1;
    vt[1].runs = '{25, 13, 12, 63, 12, 13, 12, 0,
                   0, 0, 0, 0, 0, 0, 0, 0};

    vt[2].pre = 1'b0; vt[2].flip = 1'b0;
    vt[2].nbits = 1; vt[2].bits = 4'b0001;
    vt[2].abort_at = 5; vt[2].nruns = 7; vt[2].rdy = 0;
    vt[2].runs = '{25, 13, 12, 63, 12, 38, 12, 0,
                   0, 0, 0, 0, 0, 0, 0, 0};

    vt[3].pre = 1'b1; vt[3].flip = 1'b0;
    vt[3].nbits = 3; vt[3].bits = 4'b0110;
    vt[3].abort_at = 0; vt[3].nruns = 13; vt[3].rdy = 3;
    vt[3].runs = '{25, 13, 12, 63, 12, 138, 12, 13,
                   12, 38, 12, 38, 12, 0, 0, 0};

    vt[4].pre = 1'b0; vt[4].flip = 1'b1;
    vt[4].nbits = 1; vt[4].bits = 4'b0001;
    vt[4].abort_at = 0; vt[4].nruns = 7; vt[4].rdy = 1;
    vt[4].runs = '{25, 13, 12, 63, 12, 38, 12, 0,
                   0, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1; in_dat = 1'b0; sending = 1'b0; preamble = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_env", int'(tx_env), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rdy", int'(in_rdy), 0);

    env_bad = 0; busy_bad = 0; rdy_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!tx_env) env_bad++;
      if (busy) busy_bad++;
      if (in_rdy) rdy_seen++;
    end
    chk("idle_env", env_bad, 0);
    chk("idle_busy", busy_bad, 0);
    chk("idle_rdy", rdy_seen, 0);

    for (int k = 0; k < 5; k++) begin
      run_frame(k, vt[k]);
      repeat (3) @(negedge clk);
    end

    // reset in the middle of RTcal
    in_dat = 1'b1; preamble = 1'b1; sending = 1'b1;
    fall = 0;
    for (int i = 0; i < 1000 && fall == 0; i++) begin
      @(negedge clk);
      if (!tx_env) fall = 1;
    end
    chk("mid_rst_start", fall, 1);
    repeat (70) @(negedge clk);
    chk("mid_rst_busy_pre", int'(busy), 1);
    rst = 1'b1; sending = 1'b0;
    @(negedge clk);
    chk("mid_rst_env", int'(tx_env), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rdy", int'(in_rdy), 0);
    rst = 1'b0;
    @(negedge clk);
    run_frame(5, vt[1]);

`ifdef PIE_CW_GUARD_EN
    fall = 0;
    for (int i = 1; i < 1500 && fall == 0; i++) begin
      @(negedge clk);
      if (i == 100) begin
        in_dat = 1'b0; preamble = 1'b0; sending = 1'b1;
      end
      if (!tx_env) fall = i;
    end
    sending = 1'b0;
    chk("guard_delay", fall, 500);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    chk("guard_end_busy", int'(busy), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
